// File: rtl/code_lock_pkg.sv
// Shared types and helpers for the sequence-code lock.
package code_lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    MATCH   = 3'd2,
    FAIL    = 3'd3,
    LOCKOUT = 3'd4
  } state_e;

  localparam int unsigned NO_PRESS   = 0;
  localparam int unsigned MAX_SYM_W  = 8;
  localparam int unsigned MAX_CODE_W = 128;

  // Symbol idx of a code vector; symbol 0 sits in the most significant bits.
  function automatic logic [MAX_SYM_W-1:0] sym_at(
    input logic [MAX_CODE_W-1:0] code,
    input int unsigned           idx,
    input int unsigned           code_len,
    input int unsigned           sym_w
  );
    logic [MAX_CODE_W-1:0] shifted;
    logic [MAX_SYM_W-1:0]  mask;
    shifted = code >> ((code_len - 1 - idx) * sym_w);
    mask    = (MAX_SYM_W'(1) << sym_w) - MAX_SYM_W'(1);
    return MAX_SYM_W'(shifted) & mask;
  endfunction

endpackage

// File: rtl/press_detect.sv
// Turns the debounced button level into a single-cycle press event on release->press.
module press_detect
  import code_lock_pkg::*;
#(
  parameter int unsigned SYM_W = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [SYM_W-1:0] in_i,
  output logic             press_c_o,
  output logic [SYM_W-1:0] sym_c_o
);

  logic [SYM_W-1:0] in_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_q <= '0;
    end else begin
      in_q <= in_i;
    end
  end

  // Moving between two nonzero values without release is not a new press.
  assign press_c_o = (in_i != SYM_W'(NO_PRESS)) && (in_q == SYM_W'(NO_PRESS));
  assign sym_c_o   = in_i;

endmodule

// File: rtl/code_lock_fsm.sv
// Sequence-code lock: matches a programmable code of button symbols after a start
// request, with failure counting, timed lockout and an inter-press timeout.
module code_lock_fsm
  import code_lock_pkg::*;
#(
  parameter int unsigned                    SYM_W        = 3,
  parameter int unsigned                    CODE_LEN     = 4,
  parameter logic [CODE_LEN*SYM_W-1:0]      DEFAULT_CODE = {3'b100, 3'b010, 3'b001, 3'b100},
  parameter int unsigned                    MAX_FAIL     = 3,
  parameter int unsigned                    LOCK_CYCLES  = 16,
  parameter int unsigned                    IDLE_TIMEOUT = 64
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      S,
  input  logic [SYM_W-1:0]          In,
  input  logic                      ProgEn,
  input  logic [CODE_LEN*SYM_W-1:0] ProgData,
  output logic                      U,
  output logic                      Fail,
  output logic                      Locked,
  output logic                      Busy
);

  localparam int unsigned CODE_W  = CODE_LEN * SYM_W;
  localparam int unsigned IDX_W   = $clog2(CODE_LEN);
  localparam int unsigned TMR_MAX = (IDLE_TIMEOUT > LOCK_CYCLES) ? IDLE_TIMEOUT : LOCK_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned FCNT_W  = $clog2(MAX_FAIL + 1);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                u_q, fail_q, locked_q, busy_q;

  logic                press_c;
  logic [SYM_W-1:0]    sym_c;
  logic [SYM_W-1:0]    exp_sym_c;
  logic [TMR_W-1:0]    tmr_inc_c;
  logic [FCNT_W-1:0]   fcnt_inc_c;

  press_detect #(
    .SYM_W (SYM_W)
  ) u_press_detect (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_i      (In),
    .press_c_o (press_c),
    .sym_c_o   (sym_c)
  );

  assign exp_sym_c  = SYM_W'(sym_at(MAX_CODE_W'(code_q), 32'(idx_q), CODE_LEN, SYM_W));
  assign tmr_inc_c  = (tmr_q == '1) ? tmr_q : tmr_q + TMR_W'(1);
  assign fcnt_inc_c = fcnt_q + FCNT_W'(1);

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (ProgEn) begin
          code_d = ProgData;
        end else if (S) begin
          state_d = ARMED;
          idx_d   = '0;
          tmr_d   = '0;
        end
      end
      ARMED: begin
        // A press on the timeout cycle is evaluated instead of timing out.
        if (press_c) begin
          if (sym_c != exp_sym_c) begin
            state_d = FAIL;
          end else if (idx_q == IDX_W'(CODE_LEN - 1)) begin
            state_d = MATCH;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            tmr_d = '0;
          end
        end else if (tmr_q == TMR_W'(IDLE_TIMEOUT - 1)) begin
          state_d = FAIL;
        end else begin
          tmr_d = tmr_inc_c;
        end
      end
      MATCH: begin
        fcnt_d  = '0;
        state_d = IDLE;
      end
      FAIL: begin
        if (fcnt_inc_c == FCNT_W'(MAX_FAIL)) begin
          state_d = LOCKOUT;
          tmr_d   = '0;
          fcnt_d  = '0;
        end else begin
          fcnt_d  = fcnt_inc_c;
          state_d = IDLE;
        end
      end
      LOCKOUT: begin
        if (tmr_q == TMR_W'(LOCK_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_inc_c;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      code_q   <= DEFAULT_CODE;
      idx_q    <= '0;
      tmr_q    <= '0;
      fcnt_q   <= '0;
      u_q      <= 1'b0;
      fail_q   <= 1'b0;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      tmr_q    <= tmr_d;
      fcnt_q   <= fcnt_d;
      u_q      <= (state_d == MATCH);
      fail_q   <= (state_d == FAIL);
      locked_q <= (state_d == LOCKOUT);
      busy_q   <= (state_d == ARMED);
    end
  end

  assign U      = u_q;
  assign Fail   = fail_q;
  assign Locked = locked_q;
  assign Busy   = busy_q;

endmodule
